io_bus_arbiter: RTL and testbench

//  Shares the single IO bus (io_address/io_write_value/io_read_value/io_write_en/io_read_en)

---
 rtl/io_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_io_bus_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the single IO bus between two masters (m0 = Risc16 core,
// m1 = loader/debug agent). One transaction in flight at a time, read wait states
// inserted for READ_LAT cycles, one-cycle ack per master.
// Optional build macro IO_ARB_FIXED_PRIO_EN: m0 always wins a tie (no round-robin).
module io_bus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] io_address,
  output logic [DATA_W-1:0] io_write_value,
  output logic              io_write_en,
  output logic              io_read_en,
  input  logic [DATA_W-1:0] io_read_value,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_INIT = 4'(READ_LAT);

  state_t      state, state_d;
  logic [3:0]  cnt;
  logic        lat_id;
  logic        lat_we;
  logic        sel_id;
  logic        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic        take;
  logic        capture;

`ifndef IO_ARB_FIXED_PRIO_EN
  logic        rr;
  logic        rr_d;
`endif

  assign take    = (state == S_IDLE) && (m0_req || m1_req);
  assign capture = (state == S_WAIT) && (cnt == 4'd1);

  // Winner selection for the request sampled in IDLE
  always_comb begin
`ifdef IO_ARB_FIXED_PRIO_EN
    sel_id = !m0_req;
`else
    rr_d = rr;
    if (m0_req && m1_req) begin
      sel_id = !rr;
      if (state == S_IDLE) rr_d = !rr;
    end else begin
      sel_id = !m0_req;
    end
`endif
    sel_we    = sel_id ? m1_we    : m0_we;
    sel_addr  = sel_id ? m1_addr  : m0_addr;
    sel_wdata = sel_id ? m1_wdata : m0_wdata;
  end

  // Next-state logic: IDLE -> ISSUE -> (WAIT x READ_LAT on reads) -> DONE -> IDLE
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (take) state_d = S_ISSUE;
      S_ISSUE: state_d = lat_we ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt == 4'd1) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter and latched transaction attributes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      lat_id <= 1'b0;
      lat_we <= 1'b0;
`ifndef IO_ARB_FIXED_PRIO_EN
      rr     <= 1'b1;
`endif
    end else begin
      state <= state_d;
`ifndef IO_ARB_FIXED_PRIO_EN
      rr    <= rr_d;
`endif
      if (take) begin
        lat_id <= sel_id;
        lat_we <= sel_we;
      end
      if (state == S_ISSUE)     cnt <= LAT_INIT;
      else if (state == S_WAIT) cnt <= cnt - 4'd1;
    end
  end

  // Registered bus strobes, address/data, acks, read data and busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_address     <= '0;
      io_write_value <= '0;
      io_write_en    <= 1'b0;
      io_read_en     <= 1'b0;
      m0_ack         <= 1'b0;
      m1_ack         <= 1'b0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
      busy           <= 1'b0;
    end else begin
      io_write_en <= take && sel_we;
      io_read_en  <= take && !sel_we;
      if (take) begin
        io_address     <= sel_addr;
        io_write_value <= sel_wdata;
      end
      m0_ack <= (state_d == S_DONE) && !lat_id;
      m1_ack <= (state_d == S_DONE) &&  lat_id;
      if (capture && !lat_id) m0_rdata <= io_read_value;
      if (capture &&  lat_id) m1_rdata <= io_read_value;
      busy <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: one instance with READ_LAT=1, one with READ_LAT=3.
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] io_address, io_write_value, io_read_value;
  logic        io_write_en, io_read_en, busy;

  // READ_LAT=3 instance signals
  logic        t_req;
  logic [15:0] t_addr;
  logic [15:0] t_rv;
  logic        t_zero1 = 1'b0;
  logic [15:0] t_zero16 = 16'h0;
  logic        t_m0_ack, t_m1_ack, t_we_en, t_rd_en, t_busy;
  logic [15:0] t_m0_rdata, t_m1_rdata, t_io_addr, t_io_wval;

  int n_pass = 0;
  int n_total = 0;
  int exp_id;
  logic ack_seen;

  always #5 clk = ~clk;

  io_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .io_address(io_address), .io_write_value(io_write_value),
    .io_write_en(io_write_en), .io_read_en(io_read_en),
    .io_read_value(io_read_value), .busy(busy)
  );

  io_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .m0_req(t_req), .m0_we(t_zero1), .m0_addr(t_addr), .m0_wdata(t_zero16),
    .m0_ack(t_m0_ack), .m0_rdata(t_m0_rdata),
    .m1_req(t_zero1), .m1_we(t_zero1), .m1_addr(t_zero16), .m1_wdata(t_zero16),
    .m1_ack(t_m1_ack), .m1_rdata(t_m1_rdata),
    .io_address(t_io_addr), .io_write_value(t_io_wval),
    .io_write_en(t_we_en), .io_read_en(t_rd_en),
    .io_read_value(t_rv), .busy(t_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    io_read_value = 0; t_req = 0; t_addr = 0; t_rv = 0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_acks", {m0_ack, m1_ack}, 0);
    check("rst_strobes", {io_write_en, io_read_en}, 0);
    check("rst_addr", io_address, 0);
    check("rst_rdata", {m0_rdata, m1_rdata}, 0);
    rst = 1'b0;
    tick();

    // m0 write 0x0004 <= 0xA5A5; address change after sampling must be ignored
    m0_req = 1; m0_we = 1; m0_addr = 16'h0004; m0_wdata = 16'hA5A5;
    tick();
    check("wr_issue_we", io_write_en, 1);
    check("wr_issue_re", io_read_en, 0);
    check("wr_issue_addr", io_address, 16'h0004);
    check("wr_issue_data", io_write_value, 16'hA5A5);
    check("wr_issue_ack", m0_ack, 0);
    m0_addr = 16'h0001;
    tick();
    check("wr_hold_addr", io_address, 16'h0004);
    check("wr_done_m0ack", m0_ack, 1);
    check("wr_done_m1ack", m1_ack, 0);
    check("wr_done_we", io_write_en, 0);
    m0_req = 0;
    tick();
    check("wr_idle_ack", m0_ack, 0);
    check("wr_idle_busy", busy, 0);
    check("wr_idle_addr", io_address, 16'h0004);

    // m1 read 0x0001, READ_LAT=1: only the value at the capture edge counts
    m1_req = 1; m1_we = 0; m1_addr = 16'h0001; io_read_value = 16'hDEAD;
    tick();
    check("rd_issue_re", io_read_en, 1);
    check("rd_issue_we", io_write_en, 0);
    check("rd_issue_addr", io_address, 16'h0001);
    tick();
    check("rd_wait_re", io_read_en, 0);
    check("rd_wait_ack", m1_ack, 0);
    io_read_value = 16'h1234;
    tick();
    check("rd_done_m1ack", m1_ack, 1);
    check("rd_done_m0ack", m0_ack, 0);
    check("rd_m1_rdata", m1_rdata, 16'h1234);
    check("rd_m0_rdata", m0_rdata, 16'h0000);
    io_read_value = 16'hBEEF; m1_req = 0;
    tick();
    check("rd_after_ack", m1_ack, 0);
    check("rd_rdata_hold", m1_rdata, 16'h1234);

    // Both masters held: alternate grants (fixed priority: m0 each time)
    m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_wdata = 16'h000A;
    m1_req = 1; m1_we = 1; m1_addr = 16'h0020; m1_wdata = 16'h000B;
    for (int i = 0; i < 4; i++) begin
`ifdef IO_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = i % 2;
`endif
      tick();
      check($sformatf("rr_addr_%0d", i), io_address, (exp_id == 1) ? 16'h0020 : 16'h0010);
      check($sformatf("rr_wdata_%0d", i), io_write_value, (exp_id == 1) ? 16'h000B : 16'h000A);
      tick();
      check($sformatf("rr_acks_%0d", i), {m1_ack, m0_ack}, (exp_id == 1) ? 2'b10 : 2'b01);
      if (i == 3) begin
        m0_req = 0; m1_req = 0;
      end
      tick();
    end
    tick();
    check("rr_idle_busy", busy, 0);

    // Reset during WAIT of an m0 read: transaction discarded, rdata cleared
    m0_req = 1; m0_we = 0; m0_addr = 16'h0003; io_read_value = 16'h7777;
    tick();
    tick();
    check("rst5_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("rst5_strobe", io_read_en, 0);
    check("rst5_busy", busy, 0);
    check("rst5_acks", {m0_ack, m1_ack}, 0);
    check("rst5_rdata", {m0_rdata, m1_rdata}, 0);
    m0_req = 0;
    tick();
    rst = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ack_seen = ack_seen | m0_ack;
    end
    check("rst5_no_ack", ack_seen, 0);
    m0_req = 1; m0_we = 0; m0_addr = 16'h0001; io_read_value = 16'h5555;
    tick(); tick(); tick();
    check("rst5_next_ack", m0_ack, 1);
    check("rst5_next_rdata", m0_rdata, 16'h5555);
    m0_req = 0;
    tick();

    // READ_LAT=3 read of 0x0002: capture only at the last WAIT cycle
    t_req = 1; t_addr = 16'h0002; t_rv = 16'h1111;
    tick();
    check("l3_issue_re", t_rd_en, 1);
    check("l3_issue_addr", t_io_addr, 16'h0002);
    t_rv = 16'h2222;
    tick();
    check("l3_wait1_re", t_rd_en, 0);
    t_rv = 16'h3333;
    tick();
    tick();
    check("l3_no_early_ack", t_m0_ack, 0);
    t_rv = 16'hCAFE;
    tick();
    check("l3_ack", t_m0_ack, 1);
    check("l3_rdata", t_m0_rdata, 16'hCAFE);
    t_rv = 16'h4444; t_req = 0;
    tick();
    check("l3_ack_drop", t_m0_ack, 0);
    check("l3_rdata_hold", t_m0_rdata, 16'hCAFE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
